// File: rtl/axis_2_fifo_adapter.sv
// rtl/axis_2_fifo_adapter.sv - AXI-Stream to FIFO write adapter with a two-entry skid buffer
// Packs {tuser, tlast, tdata} into FIFO words and counts completed packets.
module axis_2_fifo_adapter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH + 2,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_axis_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  input  logic                       i_axis_tlast,
  output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
  output logic                       o_fifo_w_stb,
  input  logic                       i_fifo_full,
  output logic [COUNT_WIDTH-1:0]     o_pkt_count,
  output logic                       o_idle
);

  localparam int W = FIFO_DATA_WIDTH;

  logic         out_valid;
  logic         skid_valid;
  logic [W-1:0] out_word;
  logic [W-1:0] skid_word;
  logic [W-1:0] in_word;

  logic accept;
  logic drain;
  logic out_valid_next;
  logic skid_valid_next;
  logic out_load_in;
  logic out_load_skid;
  logic skid_load;

  assign in_word = {i_axis_tuser, i_axis_tlast, i_axis_tdata[W-3:0]};

  always_comb begin
    accept          = i_axis_tvalid & o_axis_tready;
    drain           = out_valid & ~i_fifo_full;
    out_valid_next  = out_valid;
    skid_valid_next = skid_valid;
    out_load_in     = 1'b0;
    out_load_skid   = 1'b0;
    skid_load       = 1'b0;
    if (drain) begin
      if (skid_valid) begin
        out_load_skid   = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_load_in = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      // tready is low whenever the skid stage is full, so this never overwrites it
      if (!out_valid) begin
        out_load_in    = 1'b1;
        out_valid_next = 1'b1;
      end else begin
        skid_load       = 1'b1;
        skid_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      o_axis_tready <= 1'b0;
      o_pkt_count   <= '0;
    end else begin
      out_valid     <= out_valid_next;
      skid_valid    <= skid_valid_next;
      o_axis_tready <= ~skid_valid_next;
      if (drain && out_word[W-2]) begin
        o_pkt_count <= o_pkt_count + 1'b1;
      end
    end
  end

  // Data registers carry no reset; their content only matters while valid
  always_ff @(posedge clk) begin
    if (out_load_skid) begin
      out_word <= skid_word;
    end else if (out_load_in) begin
      out_word <= in_word;
    end
    if (skid_load) begin
      skid_word <= in_word;
    end
  end

  assign o_fifo_data  = out_word;
  assign o_fifo_w_stb = drain;
  assign o_idle       = ~out_valid & ~skid_valid;

endmodule

// File: doc/axis_2_fifo_adapter.md
AXIS_2_FIFO_ADAPTER -- requirements
Module: axis_2_fifo_adapter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, meaning the AXIS tdata width in bits.
REQ-002 SHALL have parameter FIFO_DATA_WIDTH, default AXIS_DATA_WIDTH+2, meaning the FIFO word width (data, last, user).
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, meaning the packet counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_axis_tuser  input  1  AXIS sideband user bit.
REQ-007 i_axis_tdata  input  AXIS_DATA_WIDTH  AXIS beat data.
REQ-008 i_axis_tvalid  input  1  AXIS beat valid.
REQ-009 o_axis_tready  output  1  AXIS ready; registered.
REQ-010 i_axis_tlast  input  1  AXIS end of packet.
REQ-011 o_fifo_data  output  FIFO_DATA_WIDTH  packed FIFO write word; registered.
REQ-012 o_fifo_w_stb  output  1  FIFO write strobe; one word written per cycle high.
REQ-013 i_fifo_full  input  1  FIFO full; no write is permitted while high.
REQ-014 o_pkt_count  output  COUNT_WIDTH  count of tlast beats written to the FIFO.
REQ-015 o_idle  output  1  high when no beat is held internally.

Function
REQ-016 SHALL pack each word as [FIFO_DATA_WIDTH-1]=tuser, [FIFO_DATA_WIDTH-2]=tlast, [FIFO_DATA_WIDTH-3:0]=tdata.
REQ-017 SHALL define accept = i_axis_tvalid & o_axis_tready, and drain = out_valid & ~i_fifo_full.
REQ-018 SHALL hold two storage stages: output stage (out_valid, out_word), which drives o_fifo_data, and skid stage (skid_valid, skid_word).
REQ-019 SHALL drive o_fifo_w_stb = drain, combinationally, so it is never high while i_fifo_full is high or the output stage is empty.
REQ-020 SHALL transition as follows, per cycle:
  - drain & skid_valid: out_word<=skid_word, skid_valid<=0.
  - drain & ~skid_valid & accept: out_word<=input.
  - drain & ~skid_valid & ~accept: out_valid<=0.
  - ~drain & ~out_valid & accept: out_word<=input, out_valid<=1.
  - ~drain & out_valid & accept: skid_word<=input, skid_valid<=1.
REQ-021 SHALL register o_axis_tready <= ~skid_valid_next, so backpressure reaches AXIS one cycle after the skid stage fills and never depends combinationally on i_fifo_full.
REQ-022 SHALL never drop, duplicate or reorder beats; FIFO write order equals AXIS accept order.
REQ-023 SHALL give latency of 1 cycle: a beat accepted in cycle N with an empty output stage (or draining with empty skid) appears with o_fifo_w_stb in cycle N+1 if i_fifo_full=0.
REQ-024 SHALL sustain 1 beat/cycle throughput with tvalid=1 and i_fifo_full=0 continuously.
REQ-025 SHALL increment o_pkt_count by 1 on each cycle where o_fifo_w_stb=1 and out_word tlast bit=1, wrapping from 2^COUNT_WIDTH-1 to 0.
REQ-026 SHALL drive o_idle = ~out_valid & ~skid_valid.
REQ-027 SHALL handle i_fifo_full asserting for an arbitrary number of cycles: at most 2 beats are held, o_axis_tready=0 from the cycle after the skid stage fills, and draining resumes the cycle i_fifo_full deasserts.
REQ-028 SHALL ignore AXIS input fields when accept=0.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear out_valid, skid_valid, o_axis_tready, and o_pkt_count to 0; o_fifo_w_stb is therefore 0 and o_idle is 1.
REQ-030 SHALL discard any held beats when reset is asserted mid-packet, with no partial write after reset.
REQ-031 SHALL drive o_axis_tready=1 on the first cycle after rst deasserts.
REQ-032 SHALL leave o_fifo_data content unspecified while o_fifo_w_stb=0.

Verification
REQ-033 Streaming: send 8 beats of data 0x0..0x7 with tvalid=1, tlast on beat 7, i_fifo_full=0 -> 8 consecutive strobes, words 0x0..0x7 each 1 cycle after accept, o_pkt_count=1.
REQ-034 Backpressure: i_fifo_full=1 while 4 beats are offered -> exactly 2 beats accepted and o_axis_tready=0; release full -> remaining beats written in order with no loss.
REQ-035 Packing: send one beat tdata=0xDEADBEEF, tuser=1, tlast=1 -> o_fifo_data=0x3DEADBEEF (34-bit).
REQ-036 Random: random tvalid and random i_fifo_full over 10k beats -> scoreboard shows no loss, duplication or reordering; o_fifo_w_stb is never high while i_fifo_full=1.
REQ-037 Counter wrap: COUNT_WIDTH=4, send 17 single-beat packets -> o_pkt_count=1.
REQ-038 Reset mid-packet: assert rst with 2 beats held and full=1 -> no strobe, o_idle=1 and o_pkt_count=0 after reset; o_axis_tready=1 on the next cycle.
